// File: rtl/flag_cond_unit32_pkg.sv
// Shared definitions for the condition-flag consumer: flag bit positions,
// the packed flag view and the 16 condition-code encodings.
package flag_cond_unit32_pkg;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

endpackage

// File: rtl/flag_cond_unit32_cond_eval32.sv
// Purely combinational condition evaluator: {n,z,c,v} plus a 4-bit condition
// code in, taken out. Shared with the predication logic.
module cond_eval32
  import flag_cond_unit32_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] code,
  output logic       taken
);

  flags_t f;

  always_comb begin
    f     = flags_t'(flags);
    taken = 1'b0;
    case (code)
      CC_EQ: taken = f.z;
      CC_NE: taken = !f.z;
      CC_CS: taken = f.c;
      CC_CC: taken = !f.c;
      CC_MI: taken = f.n;
      CC_PL: taken = !f.n;
      CC_VS: taken = f.v;
      CC_VC: taken = !f.v;
      CC_HI: taken = f.c & !f.z;
      CC_LS: taken = !f.c | f.z;
      CC_GE: taken = (f.n == f.v);
      CC_LT: taken = (f.n != f.v);
      CC_GT: taken = !f.z & (f.n == f.v);
      CC_LE: taken = f.z | (f.n != f.v);
      CC_AL: taken = 1'b1;
      // NV is reserved and simply never taken.
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit32.sv
// Condition-flag consumer: architectural NZCV register, in-flight writer
// count, and a valid/ready condition query port with a one-writer bypass.
module flag_cond_unit32
  import flag_cond_unit32_pkg::*;
#(
  parameter int MAX_PEND = 3,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       issue_set,
  input  logic       flag_wr,
  input  logic [3:0] flag_in,
  input  logic       cond_valid,
  input  logic [3:0] cond_code,
  output logic       cond_ready,
  output logic       res_valid,
  output logic       res_taken,
  input  logic       res_ready,
  output logic [3:0] flags_q,
  output logic       busy,
  output logic       err
);

  // Handshakes: a query transfers on a cycle where cond_valid & cond_ready;
  // a result transfers where res_valid & res_ready. cond_ready never looks
  // at cond_valid, and res_taken holds while res_valid & !res_ready.

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [3:0]       flags_d;
  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic             res_valid_q, res_valid_d;
  logic             res_taken_q, res_taken_d;
  logic             err_q, err_d;

  logic             cnt_zero;
  logic             bypass;
  logic             can_eval;
  logic             accept;
  logic [3:0]       eval_src;
  logic             eval_taken;

  assign cnt_zero = (pend_cnt_q == '0);
  // Last outstanding writer delivering now, with no new writer behind it.
  assign bypass   = (pend_cnt_q == ONE_CNT) & flag_wr & !issue_set;
  assign can_eval = cnt_zero | bypass;
  assign eval_src = cnt_zero ? flags_q : flag_in;

  assign cond_ready = can_eval & (!res_valid_q | res_ready);
  assign accept     = cond_valid & cond_ready;

  cond_eval32 u_cond_eval (
    .flags (eval_src),
    .code  (cond_code),
    .taken (eval_taken)
  );

  always_comb begin
    flags_d     = flags_q;
    pend_cnt_d  = pend_cnt_q;
    err_d       = err_q;
    res_valid_d = res_valid_q;
    res_taken_d = res_taken_q;

    if (flag_wr) flags_d = flag_in;

    if (issue_set && !flag_wr) begin
      if (pend_cnt_q == MAX_CNT) err_d = 1'b1;
      else                       pend_cnt_d = pend_cnt_q + ONE_CNT;
    end else if (flag_wr && !issue_set) begin
      if (cnt_zero) err_d = 1'b1;
      else          pend_cnt_d = pend_cnt_q - ONE_CNT;
    end

    if (accept) begin
      res_valid_d = 1'b1;
      res_taken_d = eval_taken;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q     <= '0;
      pend_cnt_q  <= '0;
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      pend_cnt_q  <= pend_cnt_d;
      res_valid_q <= res_valid_d;
      res_taken_q <= res_taken_d;
      err_q       <= err_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_taken = res_taken_q;
  assign busy      = !cnt_zero;
  assign err       = err_q;

endmodule

// File: doc/flag_cond_unit32.md
Name: flag_cond_unit32

Overview:
- Consumer end of the ALU condition-flag interface. Latches the N/Z/C/V flags written by the 32-bit ALU flag logic into an architectural status register.
- Tracks how many flag-setting ALU ops are still in flight.
- Answers condition-code queries from the branch/predication stage through a valid/ready handshake.
- Stalls a query until all older flag writers have retired, with a one-writer bypass path.

Parameters:
- MAX_PEND, 3, maximum number of in-flight flag-setting ALU ops (1..15).
- CNT_W, 4, width of the pending counter; must satisfy 2^CNT_W > MAX_PEND.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- issue_set  in  1  a flag-setting ALU op issued this cycle
- flag_wr  in  1  ALU delivers flags this cycle (retires one pending op)
- flag_in  in  4  {n,z,c,v}: bit3=n, bit2=z, bit1=c, bit0=v
- cond_valid  in  1  condition query valid
- cond_code  in  4  condition code, encoding below
- cond_ready  out  1  query accepted this cycle when cond_valid & cond_ready
- res_valid  out  1  result register holds an unconsumed answer
- res_taken  out  1  evaluated condition (1 = condition true)
- res_ready  in  1  downstream consumes the result when res_valid & res_ready
- flags_q  out  4  architectural flags {n,z,c,v}
- busy  out  1  pend_cnt != 0
- err  out  1  sticky protocol error flag

Behaviour:
- Reset (async, reset_n=0): flags_q=0, pend_cnt=0, res_valid=0, res_taken=0, err=0. Reset mid-handshake drops any held result without emitting it.
- flags_q update: if flag_wr, flags_q <= flag_in on the next edge. Otherwise flags_q holds.
- pend_cnt update:
  - issue_set & !flag_wr: +1
  - flag_wr & !issue_set: -1
  - both asserted: unchanged
- Overflow: issue_set with pend_cnt==MAX_PEND and no flag_wr sets err; the counter saturates.
- Underflow: flag_wr with pend_cnt==0 and no issue_set sets err; the counter stays 0 and flags_q still updates.
- err clears only on reset.
- Eval source, in priority order:
  - pend_cnt==0: use flags_q.
  - pend_cnt==1 & flag_wr & !issue_set: bypass, use flag_in.
  - otherwise: stalled, can_eval=0.
- Same-cycle ordering: a query accepted in the same cycle as issue_set is older than that op and uses the current source.
- Handshake: cond_ready = can_eval & (!res_valid | res_ready). This is combinational and independent of cond_valid.
- Latency: on accept, res_taken <= eval(src, cond_code) and res_valid <= 1 at the next edge (1-cycle latency).
- Result register:
  - If res_valid & res_ready and no new accept: res_valid <= 0.
  - Accept and consume in the same cycle: back-to-back, res_valid stays 1 with the new value.
  - Held result: res_taken is stable while res_valid & !res_ready.
- Implicit states: READY (pend_cnt==0), PENDING (pend_cnt>0, queries stall), BYPASS (transient READY via flag_in).
- Condition encoding and evaluation:
  - 0 EQ: z
  - 1 NE: !z
  - 2 CS: c
  - 3 CC: !c
  - 4 MI: n
  - 5 PL: !n
  - 6 VS: v
  - 7 VC: !v
  - 8 HI: c&!z
  - 9 LS: !c|z
  - A GE: n==v
  - B LT: n!=v
  - C GT: !z&(n==v)
  - D LE: z|(n!=v)
  - E AL: 1
  - F NV: 0 (reserved, no error)
- busy = (pend_cnt != 0), registered from the counter.

Decomposition:
- Shared package: flag bit indices (FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0) and the 16 condition-code localparams (CC_EQ .. CC_NV).
- Sub-module cond_eval32: purely combinational, inputs {flags[3:0], code[3:0]}, output taken. Reused by future predication logic.
- Top module holds the counter, flag register, result register and handshake.

Test Plan:
- After reset, flag_wr=1 with flag_in=4'b0100 (Z), then query cond_code=0 (EQ) -> cond_ready=1, next cycle res_valid=1, res_taken=1. Query cond_code=1 (NE) -> res_taken=0.
- issue_set twice, then cond_valid with code A (GE) -> cond_ready=0, busy=1.
  - flag_wr {n=1,v=0}: still stalled (cnt 2->1).
  - Second flag_wr {n=1,v=1}: accepted via bypass that cycle, res_taken=1.
- Simultaneous issue_set & flag_wr with pend_cnt=1 -> pend_cnt stays 1, flags_q updated, query still stalled, err=0.
- Hold res_ready=0 with res_valid=1 -> cond_ready=0, res_taken stable for 5 cycles. Then assert res_ready with a new query -> back-to-back, res_valid never drops.
- Error paths:
  - With MAX_PEND=3: 4 issue_set pulses -> err=1, pend_cnt=3.
  - After reset: flag_wr with pend_cnt=0 -> err=1, flags_q updated.
- Sweep all 16 codes against all 16 flag values against a model. Check code F -> 0 and code E -> 1. Assert reset_n low mid-result -> res_valid=0 immediately.
